// File: rtl/postadder_sched_pkg.sv
// Shared types and constants for the postadder command scheduler.
// Holds the mode/accumulator encodings and the term-counter index mapping.
package postadder_sched_pkg;

  typedef enum logic [2:0] {
    PA_HOLD   = 3'b000,
    PA_LOAD   = 3'b001,
    PA_ADD    = 3'b010,
    PA_SUB    = 3'b011,
    PA_RSUB   = 3'b100,
    PA_NEGMOD = 3'b101
  } pa_mode_t;

  typedef enum logic [1:0] {
    PA_ACC1    = 2'b00,
    PA_ACC2    = 2'b01,
    PA_ACC3    = 2'b10,
    PA_ACC_ILL = 2'b11
  } pa_acc_t;

  localparam int PA_ACC_LAT   = 1;
  localparam int PA_L3_CARRY  = 8;
  localparam int PA_MAX_TERMS = 2 ** (PA_L3_CARRY - 1);
  localparam int PA_N_SLOT    = 4;
  localparam int PA_N_CNT     = 1 + 2 * PA_N_SLOT;
  localparam int PA_CNT_W     = $clog2(PA_MAX_TERMS + 1);
  localparam int PA_IDX_W     = $clog2(PA_N_CNT);
  localparam int PA_ACC_W     = 2;
  localparam int PA_MODE_W    = 3;
  localparam int PA_ADDR_W    = 2;

  // Flat counter index: acc1 -> 0, acc2 slots -> 1..N_SLOT, acc3 slots after that.
  function automatic logic [PA_IDX_W-1:0] pa_cnt_index(input logic [PA_ACC_W-1:0]  acc,
                                                       input logic [PA_ADDR_W-1:0] addr);
    case (acc)
      PA_ACC1: pa_cnt_index = '0;
      PA_ACC2: pa_cnt_index = PA_IDX_W'(1) + PA_IDX_W'(addr);
      default: pa_cnt_index = PA_IDX_W'(1 + PA_N_SLOT) + PA_IDX_W'(addr);
    endcase
  endfunction

endpackage

// File: rtl/postadder_sched_if.sv
// Command and result handshake bundle between upstream, the scheduler and reduction.
interface postadder_sched_if;
  import postadder_sched_pkg::*;

  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [PA_ACC_W-1:0]  cmd_acc;
  logic [PA_MODE_W-1:0] cmd_mode;
  logic [PA_ADDR_W-1:0] cmd_addr;
  logic                 cmd_last;
  logic                 res_valid;
  logic                 res_ready;
  logic [PA_ACC_W-1:0]  res_acc;

  modport master (
    output cmd_valid, cmd_acc, cmd_mode, cmd_addr, cmd_last, res_ready,
    input  cmd_ready, res_valid, res_acc
  );

  modport slave (
    input  cmd_valid, cmd_acc, cmd_mode, cmd_addr, cmd_last, res_ready,
    output cmd_ready, res_valid, res_acc
  );
endinterface

// File: rtl/postadder_sched_term_counter.sv
// Bank of per-slot term counters guarding the L3 carry headroom.
// sat reports whether the selected slot already holds MAX terms.
module pa_term_counter
  import postadder_sched_pkg::*;
#(
  parameter int N_CNT = PA_N_CNT,
  parameter int CNT_W = PA_CNT_W,
  parameter int IDX_W = PA_IDX_W,
  parameter int MAX   = PA_MAX_TERMS
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [IDX_W-1:0] sel,
  input  logic             load,
  input  logic             incr,
  input  logic             clr,
  input  logic [IDX_W-1:0] clr_sel,
  output logic             sat
);

  logic [CNT_W-1:0] cnt [N_CNT];

  // Clear from result retirement wins; it never coincides with an accepted command anyway.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < N_CNT; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_CNT; i++) begin
        if (clr && clr_sel == IDX_W'(i))
          cnt[i] <= '0;
        else if (load && sel == IDX_W'(i))
          cnt[i] <= CNT_W'(1);
        else if (incr && sel == IDX_W'(i))
          cnt[i] <= cnt[i] + CNT_W'(1);
      end
    end
  end

  always_comb begin
    sat = 1'b0;
    for (int i = 0; i < N_CNT; i++)
      if (sel == IDX_W'(i)) sat = (cnt[i] == CNT_W'(MAX));
  end

endmodule

// File: rtl/postadder_sched.sv
// Postadder command scheduler: issues registered modes/addresses per accepted micro-op,
// guards term headroom, and presents finished results over a valid/ready handshake.
module postadder_sched
  import postadder_sched_pkg::*;
(
  input  logic                 clk,
  input  logic                 rstn,
  postadder_sched_if.slave     bus,
  output logic [PA_MODE_W-1:0] mode1,
  output logic [PA_MODE_W-1:0] mode2,
  output logic [PA_MODE_W-1:0] mode3,
  output logic [PA_ADDR_W-1:0] addr2,
  output logic [PA_ADDR_W-1:0] addr3,
  output logic [PA_ACC_W-1:0]  outsel,
  output logic                 err_ovf,
  output logic                 err_ill,
  output logic                 busy
);

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_DRAIN   = 2'd1;
  localparam logic [1:0] ST_PRESENT = 2'd2;
  localparam int         LAT_W      = $clog2(PA_ACC_LAT + 1);

  logic [1:0]           state;
  logic [LAT_W-1:0]     drain_cnt;
  logic                 accept, cmd_ill, cmd_ok, is_load, is_incr, sat, ovf, retire;
  logic [PA_MODE_W-1:0] issue_mode;
  logic [PA_IDX_W-1:0]  sel_idx, clr_idx;

  assign bus.cmd_ready = rstn && (state == ST_RUN);
  assign bus.res_valid = (state == ST_PRESENT);
  assign bus.res_acc   = outsel;
  assign busy          = (state != ST_RUN);

  assign accept     = bus.cmd_valid && bus.cmd_ready;
  assign cmd_ill    = (bus.cmd_acc == PA_ACC_ILL) || (bus.cmd_mode > PA_NEGMOD);
  assign cmd_ok     = accept && !cmd_ill;
  assign is_load    = (bus.cmd_mode == PA_LOAD);
  assign is_incr    = (bus.cmd_mode != PA_HOLD) && !is_load;
  assign ovf        = cmd_ok && is_incr && sat;
  assign issue_mode = ovf ? PA_HOLD : bus.cmd_mode;
  assign retire     = (state == ST_PRESENT) && bus.res_ready;
  assign sel_idx    = pa_cnt_index(bus.cmd_acc, bus.cmd_addr);
  assign clr_idx    = pa_cnt_index(outsel, (outsel == PA_ACC2) ? addr2 : addr3);

  pa_term_counter u_cnt (
    .clk     (clk),
    .rstn    (rstn),
    .sel     (sel_idx),
    .load    (cmd_ok && is_load),
    .incr    (cmd_ok && is_incr && !sat),
    .clr     (retire),
    .clr_sel (clr_idx),
    .sat     (sat)
  );

  // Modes are single-cycle pulses; addresses and outsel persist for the drain/present window.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      mode1     <= PA_HOLD;
      mode2     <= PA_HOLD;
      mode3     <= PA_HOLD;
      addr2     <= '0;
      addr3     <= '0;
      outsel    <= '0;
      err_ovf   <= 1'b0;
      err_ill   <= 1'b0;
      state     <= ST_RUN;
      drain_cnt <= '0;
    end else begin
      mode1 <= PA_HOLD;
      mode2 <= PA_HOLD;
      mode3 <= PA_HOLD;
      if (cmd_ok) begin
        case (bus.cmd_acc)
          PA_ACC1: mode1 <= issue_mode;
          PA_ACC2: begin
            mode2 <= issue_mode;
            addr2 <= bus.cmd_addr;
          end
          default: begin
            mode3 <= issue_mode;
            addr3 <= bus.cmd_addr;
          end
        endcase
        if (bus.cmd_last) outsel <= bus.cmd_acc;
      end
      if (ovf) err_ovf <= 1'b1;
      if (accept && cmd_ill) err_ill <= 1'b1;

      case (state)
        ST_RUN: begin
          if (cmd_ok && bus.cmd_last) begin
            state     <= ST_DRAIN;
            drain_cnt <= '0;
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == LAT_W'(PA_ACC_LAT - 1)) state <= ST_PRESENT;
          else drain_cnt <= drain_cnt + LAT_W'(1);
        end
        ST_PRESENT: if (retire) state <= ST_RUN;
        default: state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_postadder_sched.sv
// Self-checking bench for postadder_sched against a cycle-level reference of its
// command/result rules (term counts per slot, drain latency, sticky errors).
module tb_postadder_sched;
  import postadder_sched_pkg::*;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [2:0] mode1, mode2, mode3;
  logic [1:0] addr2, addr3, outsel;
  logic       err_ovf, err_ill, busy;

  postadder_sched_if bus ();

  postadder_sched dut (
    .clk     (clk),
    .rstn    (rstn),
    .bus     (bus),
    .mode1   (mode1),
    .mode2   (mode2),
    .mode3   (mode3),
    .addr2   (addr2),
    .addr3   (addr3),
    .outsel  (outsel),
    .err_ovf (err_ovf),
    .err_ill (err_ill),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int         tests = 0;
  int         fails = 0;
  int         cnt[3][4];
  bit         m_ovf, m_ill, m_drain, m_present;
  int         m_drain_left, m_pacc, m_pslot;
  logic [2:0] m_mode[3];
  logic [1:0] m_addr2, m_addr3, m_outsel;

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int a = 0; a < 3; a++) begin
      for (int s = 0; s < 4; s++) cnt[a][s] = 0;
      m_mode[a] = 3'd0;
    end
    m_ovf = 0; m_ill = 0; m_drain = 0; m_present = 0; m_drain_left = 0;
    m_addr2 = 2'd0; m_addr3 = 2'd0; m_outsel = 2'd0; m_pacc = 0; m_pslot = 0;
  endtask

  // One clock of stimulus, reference update and output comparison.
  task automatic applyStimulus(input bit r, input bit v, input logic [1:0] acc,
                               input logic [2:0] mode, input logic [1:0] addr,
                               input bit last, input bit rr);
    bit accept;
    int a, s;
    @(negedge clk);
    rstn = r; bus.cmd_valid = v; bus.cmd_acc = acc; bus.cmd_mode = mode;
    bus.cmd_addr = addr; bus.cmd_last = last; bus.res_ready = rr;
    accept = r && v && !m_drain && !m_present;
    @(posedge clk);
    if (!r) modelReset();
    else begin
      for (int k = 0; k < 3; k++) m_mode[k] = 3'd0;
      if (m_present) begin
        if (rr) begin
          m_present = 0;
          cnt[m_pacc][m_pslot] = 0;
        end
      end else if (m_drain) begin
        m_drain_left--;
        if (m_drain_left == 0) begin m_drain = 0; m_present = 1; end
      end
      if (accept) begin
        if (acc == 2'd3 || mode > 3'd5) m_ill = 1;
        else begin
          a = int'(acc);
          s = (a == 0) ? 0 : int'(addr);
          if (a == 1) m_addr2 = addr;
          if (a == 2) m_addr3 = addr;
          if (mode == 3'd1) begin cnt[a][s] = 1; m_mode[a] = mode; end
          else if (mode != 3'd0) begin
            if (cnt[a][s] >= PA_MAX_TERMS) m_ovf = 1;
            else begin cnt[a][s]++; m_mode[a] = mode; end
          end
          if (last) begin
            m_outsel = acc; m_drain = 1; m_drain_left = PA_ACC_LAT;
            m_pacc = a; m_pslot = s;
          end
        end
      end
    end
    #1;
    checkOutput("cmd_ready", 8'(bus.cmd_ready), 8'(r && !m_drain && !m_present));
    checkOutput("res_valid", 8'(bus.res_valid), 8'(m_present));
    checkOutput("res_acc", 8'(bus.res_acc), 8'(m_outsel));
    checkOutput("outsel", 8'(outsel), 8'(m_outsel));
    checkOutput("mode1", 8'(mode1), 8'(m_mode[0]));
    checkOutput("mode2", 8'(mode2), 8'(m_mode[1]));
    checkOutput("mode3", 8'(mode3), 8'(m_mode[2]));
    checkOutput("addr2", 8'(addr2), 8'(m_addr2));
    checkOutput("addr3", 8'(addr3), 8'(m_addr3));
    checkOutput("err_ovf", 8'(err_ovf), 8'(m_ovf));
    checkOutput("err_ill", 8'(err_ill), 8'(m_ill));
    checkOutput("busy", 8'(busy), 8'(m_drain || m_present));
  endtask

  task automatic idle(input int n, input bit rr);
    for (int i = 0; i < n; i++) applyStimulus(1, 0, 2'd0, 3'd0, 2'd0, 0, rr);
  endtask

  initial begin
    logic [2:0] md;
    bus.cmd_valid = 0; bus.cmd_acc = 0; bus.cmd_mode = 0; bus.cmd_addr = 0;
    bus.cmd_last = 0; bus.res_ready = 0;
    modelReset();

    // Reset held, then released.
    for (int i = 0; i < 10; i++) applyStimulus(0, 1, 2'd1, 3'd2, 2'd1, 0, 0);
    idle(1, 0);

    // acc2 slot1: load + 126 adds, last on final add; hold the result, then retire.
    applyStimulus(1, 1, 2'd1, 3'd1, 2'd1, 0, 0);
    for (int i = 0; i < 126; i++) applyStimulus(1, 1, 2'd1, 3'd2, 2'd1, i == 125, 0);
    idle(3, 0);
    idle(1, 1);
    // After retirement the slot starts from zero: 128 adds fit without overflow.
    for (int i = 0; i < 128; i++) applyStimulus(1, 1, 2'd1, 3'd2, 2'd1, 0, 0);
    applyStimulus(1, 1, 2'd1, 3'd1, 2'd1, 0, 0);

    // acc1: 128 terms, then one add too many carrying last.
    applyStimulus(1, 1, 2'd0, 3'd1, 2'd2, 0, 0);
    for (int i = 0; i < 127; i++) applyStimulus(1, 1, 2'd0, 3'd2, 2'd2, 0, 0);
    applyStimulus(1, 1, 2'd0, 3'd2, 2'd2, 1, 0);
    idle(2, 1);

    // Interleaved accumulators with random arithmetic modes and slots.
    for (int i = 0; i < 60; i++) begin
      md = 3'($urandom_range(2, 5));
      applyStimulus(1, 1, 2'($urandom_range(0, 2)), md, 2'($urandom_range(0, 3)), 0, 0);
    end
    applyStimulus(1, 1, 2'd2, 3'd4, 2'd3, 1, 0);
    idle(2, 1);

    // Illegal commands are consumed with no effect except err_ill.
    applyStimulus(1, 1, 2'd3, 3'd2, 2'd1, 1, 0);
    applyStimulus(1, 1, 2'd1, 3'd6, 2'd0, 1, 0);
    applyStimulus(1, 1, 2'd0, 3'd7, 2'd0, 1, 0);
    idle(1, 0);

    // Stalled result with a pending command, then retire-vs-accept collision.
    applyStimulus(1, 1, 2'd2, 3'd3, 2'd2, 1, 0);
    for (int i = 0; i < 6; i++) applyStimulus(1, 1, 2'd1, 3'd2, 2'd0, 0, 0);
    applyStimulus(1, 1, 2'd1, 3'd2, 2'd0, 0, 1);
    applyStimulus(1, 1, 2'd1, 3'd2, 2'd0, 0, 0);

    // Reset while draining discards the result.
    applyStimulus(1, 1, 2'd1, 3'd2, 2'd3, 1, 0);
    applyStimulus(0, 0, 2'd0, 3'd0, 2'd0, 0, 1);
    idle(3, 1);

    // Randomised traffic, including rare resets and illegal encodings.
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 99) != 0, $urandom_range(0, 3) != 0,
                    2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                    2'($urandom_range(0, 3)), $urandom_range(0, 7) == 0,
                    $urandom_range(0, 1) == 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
